fac_engine: RTL and testbench

- Parametrised factorial engine: a successor to the 2-bit factorial next-state controller.
- Integrates the INIT/OFFS/FACT/DONE state machine with the datapath: operand latch, down-counter, iterative multiplier and sticky overflow detection.
- Sits behind the bus register bank. opstart and opclear are driven from register bit0; result, opdone and overflow are read back through the same bank.

---
 rtl/fac_engine.sv | 151 +++++++++++++++
 tb/tb_fac_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fac_engine.sv
// Iterative factorial engine: INIT/OFFS/FACT/DONE controller with operand latch,
// down-counter, one multiply per cycle and sticky overflow. Define FAC_INTR_EN for irq_o/irq_ack_i.
module fac_engine #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned N_W    = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              opstart_i,
  input  logic              opclear_i,
  input  logic [N_W-1:0]    operand_i,
  output logic [DATA_W-1:0] result_o,
  output logic              opdone_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [1:0]        state_o
`ifdef FAC_INTR_EN
  ,
  output logic              irq_o,
  input  logic              irq_ack_i
`endif
);

  localparam int unsigned PW = DATA_W + N_W;

  typedef enum logic [1:0] {
    StInit = 2'b00,
    StOffs = 2'b01,
    StFact = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [N_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     prod;
  logic              cnt_le1;

  assign prod    = PW'(acc_q) * PW'(cnt_q);
  assign cnt_le1 = (cnt_q <= N_W'(1));

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; opclear always wins. n<=1 still spends one cycle in FACT,
  // where cnt<=1 immediately yields result=acc=1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: if (!opclear_i && opstart_i) state_d = StOffs;
      StOffs: state_d = opclear_i ? StInit : StFact;
      StFact: begin
        if (opclear_i)    state_d = StInit;
        else if (cnt_le1) state_d = StDone;
      end
      StDone: begin
        if (opclear_i)      state_d = StInit;
        else if (opstart_i) state_d = StOffs;
      end
      default: state_d = StInit;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    busy_o     = (state_q == StOffs) || (state_q == StFact);
    opdone_o   = (state_q == StDone);
    state_o    = state_q;
    result_o   = result_q;
    overflow_o = ovf_q;
  end

  // Datapath next-state
  always_comb begin
    n_d      = n_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (opclear_i) begin
      result_d = '0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        StInit, StDone: if (opstart_i) n_d = operand_i;
        StOffs: begin
          acc_d = DATA_W'(1);
          cnt_d = n_q;
          ovf_d = 1'b0;
        end
        StFact: begin
          if (cnt_le1) begin
            result_d = acc_q;
          end else begin
            acc_d = prod[DATA_W-1:0];
            ovf_d = ovf_q | (|prod[PW-1:DATA_W]);
            cnt_d = cnt_q - N_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      n_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef FAC_INTR_EN
  logic irq_q, irq_d;

  // Set on DONE entry beats ack/clear on the same edge
  always_comb begin
    irq_d = irq_q;
    if ((state_q != StDone) && (state_d == StDone)) irq_d = 1'b1;
    else if (irq_ack_i || opclear_i)                 irq_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_fac_engine.sv
// Self-checking bench for fac_engine: directed corner cases plus random operands
// checked against a plain-arithmetic factorial model.
module tb_fac_engine;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned N_W    = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              opstart, opclear;
  logic [N_W-1:0]    operand;
  logic [DATA_W-1:0] result;
  logic              opdone, busy, overflow;
  logic [1:0]        state;
`ifdef FAC_INTR_EN
  logic              irq, irq_ack;
`endif

  int total = 0;
  int bad   = 0;

  fac_engine #(.DATA_W(DATA_W), .N_W(N_W)) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .opstart_i  (opstart),
    .opclear_i  (opclear),
    .operand_i  (operand),
    .result_o   (result),
    .opdone_o   (opdone),
    .busy_o     (busy),
    .overflow_o (overflow),
    .state_o    (state)
`ifdef FAC_INTR_EN
    ,
    .irq_o      (irq),
    .irq_ack_i  (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned fact_mod(input int n);
    longint unsigned r = 1;
    for (int k = 2; k <= n; k++) r = r * longint'(k);
    return r;
  endfunction

  // 20! < 2^64 <= 21!, and every partial product is bounded by n!
  function automatic bit fact_ovf(input int n);
    return n >= 21;
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_opdone"}, 64'(opdone), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
`ifdef FAC_INTR_EN
    chk({tag, "_irq"}, 64'(irq), 64'd0);
`endif
  endtask

  // Start an operation (from INIT or DONE) and wait for DONE; hold keeps opstart high.
  task automatic do_op(input int n, input bit hold);
    int edges = 0;
    @(negedge clk);
    opstart = 1'b1;
    operand = N_W'(n);
    @(posedge clk); #1;
    chk("e0_state", 64'(state), 64'd1);
    @(negedge clk);
    if (!hold) opstart = 1'b0;
    operand = N_W'($urandom);
    while (opdone !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (opdone !== 1'b1) begin
        chk("busy", 64'(busy), 64'd1);
`ifdef FAC_INTR_EN
        chk("irq_low", 64'(irq), 64'd0);
`endif
      end
    end
    chk("latency", 64'(edges), (n >= 2) ? 64'(n + 1) : 64'd2);
    chk("result", result, fact_mod(n));
    chk("ovf", 64'(overflow), 64'(fact_ovf(n)));
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_state", 64'(state), 64'd3);
    @(negedge clk);
    opstart = 1'b0;
`ifdef FAC_INTR_EN
    chk("irq_set", 64'(irq), 64'd1);
    irq_ack = 1'b1;
    @(posedge clk); #1;
    chk("irq_ack", 64'(irq), 64'd0);
    chk("ack_state", 64'(state), 64'd3);
    @(negedge clk);
    irq_ack = 1'b0;
`endif
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    opclear = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    opclear = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    opstart = 1'b0;
    opclear = 1'b0;
    operand = '0;
`ifdef FAC_INTR_EN
    irq_ack = 1'b0;
`endif
    #1;
    idle_checks("rst");
    @(negedge clk);
    reset = 1'b0;

    // Directed operands, back-to-back from DONE
    do_op(5, 1'b0);
    do_op(0, 1'b0);
    do_op(1, 1'b0);
    do_op(20, 1'b0);
    do_op(21, 1'b0);
    clear_pulse();
    idle_checks("clr21");

    // opstart held through FACT is ignored
    do_op(7, 1'b1);

    // start+clear together in DONE and in INIT
    @(negedge clk);
    opstart = 1'b1;
    opclear = 1'b1;
    @(posedge clk); #1;
    idle_checks("both_done");
    @(posedge clk); #1;
    idle_checks("both_init");
    @(negedge clk);
    opstart = 1'b0;
    opclear = 1'b0;

    // Abort on the 3rd FACT cycle of n=8
    @(negedge clk);
    opstart = 1'b1;
    operand = N_W'(8);
    @(posedge clk); #1;
    @(negedge clk);
    opstart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre", 64'(state), 64'd2);
    @(negedge clk);
    opclear = 1'b1;
    @(posedge clk); #1;
    idle_checks("abort");
    @(negedge clk);
    opclear = 1'b0;
    begin
      int seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (opdone) seen++;
      end
      chk("abort_nodone", 64'(seen), 64'd0);
    end

    // Asynchronous reset mid-FACT
    @(negedge clk);
    opstart = 1'b1;
    operand = N_W'(10);
    @(posedge clk); #1;
    @(negedge clk);
    opstart = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_state", 64'(state), 64'd2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    idle_checks("async_rst");
    @(negedge clk);
    reset = 1'b0;

    // Random operands
    for (int i = 0; i < 12; i++) do_op(int'($urandom_range(0, 63)), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
